// File: rtl/nand_io_sequencer_if.sv
// nand_io_sequencer_if: IO-unit and page-buffer bus driven by the sequencer
interface nand_io_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
);
    logic              io_activate;
    logic              io_type;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_busy;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;

    modport master (
        output io_activate, io_type, io_wdata, buf_addr, buf_wdata, buf_we,
        input  io_rdata, io_busy, buf_rdata
    );

    modport slave (
        input  io_activate, io_type, io_wdata, buf_addr, buf_wdata, buf_we,
        output io_rdata, io_busy, buf_rdata
    );
endinterface

// File: rtl/nand_io_sequencer.sv
// nand_io_sequencer: moves a burst of words between the page buffer and the NAND IO unit
module nand_io_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 13,
    parameter int ARM_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] words_done,
    nand_io_sequencer_if.master io
);
    localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);

    typedef enum logic [3:0] {IDLE, FETCH, LOAD, ACT, ARM, WAIT, STORE, NEXT, DONE} state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] wd_q, wd_d;
    logic              aborted_q, aborted_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] wd_inc;

    assign wd_inc = wd_q + ADDR_W'(1);

    // State and datapath registers; reset abandons any burst without waiting on the IO unit
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            len_q     <= '0;
            ptr_q     <= '0;
            wd_q      <= '0;
            aborted_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            aborted_q <= aborted_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next state and datapath updates; abort ends the burst before activate, else waits for NEXT
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        aborted_d = aborted_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        wdata_d   = io.io_wdata;
        case (state_q)
            IDLE: if (start) begin
                dir_d     = dir;
                len_d     = length;
                ptr_d     = base_addr;
                wd_d      = '0;
                aborted_d = 1'b0;
                timeout_d = 1'b0;
                state_d   = (length == '0) ? DONE : dir ? FETCH : ACT;
            end
            FETCH: begin
                state_d   = abort ? DONE : LOAD;
                aborted_d = aborted_q | abort;
            end
            LOAD: begin
                state_d   = abort ? DONE : ACT;
                aborted_d = aborted_q | abort;
            end
            ACT: begin
                state_d   = abort ? DONE : io.io_busy ? ACT : ARM;
                aborted_d = aborted_q | abort;
                cnt_d     = CNT_W'(ARM_TIMEOUT);
            end
            ARM: if (!io.io_busy) begin
                cnt_d     = cnt_q - CNT_W'(1);
                timeout_d = cnt_q <= CNT_W'(1);
                state_d   = (cnt_q <= CNT_W'(1)) ? DONE : ARM;
            end else begin
                state_d   = WAIT;
            end
            WAIT:  state_d = io.io_busy ? WAIT : dir_q ? NEXT : STORE;
            STORE: state_d = NEXT;
            NEXT: begin
                wd_d      = wd_inc;
                ptr_d     = ptr_q + ADDR_W'(1);
                aborted_d = abort && (wd_inc != len_q);
                state_d   = (wd_inc == len_q || abort) ? DONE : dir_q ? FETCH : ACT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; write data follows the buffer during LOAD and is then held for the IO unit
    always_comb begin
        busy           = state_q != IDLE;
        done           = state_q == DONE;
        aborted        = aborted_q;
        timeout_err    = timeout_q;
        words_done     = wd_q;
        io.io_activate = (state_q == ACT) && !abort && !io.io_busy;
        io.io_type     = dir_q;
        io.io_wdata    = (state_q == LOAD) ? io.buf_rdata : wdata_q;
        io.buf_addr    = ptr_q;
        io.buf_we      = state_q == STORE;
        io.buf_wdata   = (state_q == STORE) ? io.io_rdata : '0;
    end
endmodule

// File: tb/tb_nand_io_sequencer.sv
// tb_nand_io_sequencer: directed bursts against an IO-unit and page-buffer model
module tb_nand_io_sequencer;
    localparam int DW = 16;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] length = '0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, aborted, timeout_err;
    logic [AW-1:0] words_done;

    nand_io_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) io ();

    nand_io_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ARM_TIMEOUT(8)) dut (
        .clk(clk), .nreset(nreset), .start(start), .dir(dir), .length(length),
        .base_addr(base_addr), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .timeout_err(timeout_err), .words_done(words_done), .io(io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [DW-1:0] act_d [$];
    int            act_n = 0;
    int            act_mark = 0;
    int            done_n = 0;
    int            bcnt;
    int            busy_len = 5;
    logic          never_busy = 1'b0;
    logic [DW-1:0] prev_wdata = '0;

    assign io.io_busy = bcnt > 0;

    always @(posedge clk) begin
        io.buf_rdata <= mem[io.buf_addr];
        if (io.buf_we) begin
            mem[io.buf_addr] <= io.buf_wdata;
            wr_a.push_back(io.buf_addr);
            wr_d.push_back(io.buf_wdata);
        end
    end

    always @(posedge clk or negedge nreset) begin
        if (!nreset) bcnt <= 0;
        else if (io.io_activate && !never_busy) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end

    always @(posedge clk) begin
        if (io.io_activate) begin
            chk("act_while_busy", {31'b0, io.io_busy}, 0);
            if (io.io_type) chk("wdata_stable", io.io_wdata, prev_wdata);
            act_d.push_back(io.io_wdata);
            io.io_rdata <= DW'(16'h1111 * (act_n - act_mark + 1));
            act_n++;
        end
        prev_wdata = io.io_wdata;
        if (done) done_n++;
    end

    task automatic go(input logic d, input logic [AW-1:0] len, input logic [AW-1:0] base);
        @(negedge clk);
        dir = d;
        length = len;
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {31'b0, done}, 1);
    endtask

    initial begin
        int a0, d0, w0, n;
        mem[13'h010] <= 16'hA1A1;
        mem[13'h011] <= 16'hB2B2;
        mem[13'h012] <= 16'hC3C3;
        mem[13'h100] <= 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_flags", {30'b0, aborted, timeout_err}, 0);
        chk("rst_words", {19'b0, words_done}, 0);
        chk("rst_io", {15'b0, io.io_activate, io.buf_we, io.io_wdata}, 0);
        nreset = 1'b1;

        a0 = act_d.size(); d0 = done_n; w0 = wr_a.size();
        go(1'b1, 13'd3, 13'h010);
        wait_done("wr");
        chk("wr_words", {19'b0, words_done}, 3);
        chk("wr_aborted", {31'b0, aborted}, 0);
        @(negedge clk);
        chk("wr_busy_low", {31'b0, busy}, 0);
        chk("wr_acts", act_d.size() - a0, 3);
        chk("wr_data0", act_d[a0], 16'hA1A1);
        chk("wr_data1", act_d[a0+1], 16'hB2B2);
        chk("wr_data2", act_d[a0+2], 16'hC3C3);
        chk("wr_dones", done_n - d0, 1);
        chk("wr_no_bufwe", wr_a.size() - w0, 0);

        act_mark = act_n; a0 = act_d.size(); d0 = done_n; w0 = wr_a.size();
        go(1'b0, 13'd4, 13'h1FFE);
        wait_done("rd");
        chk("rd_words", {19'b0, words_done}, 4);
        @(negedge clk);
        chk("rd_acts", act_d.size() - a0, 4);
        chk("rd_writes", wr_a.size() - w0, 4);
        chk("rd_a0", wr_a[w0], 13'h1FFE);
        chk("rd_a1", wr_a[w0+1], 13'h1FFF);
        chk("rd_a2", wr_a[w0+2], 13'h0000);
        chk("rd_a3", wr_a[w0+3], 13'h0001);
        chk("rd_d0", wr_d[w0], 16'h1111);
        chk("rd_d1", wr_d[w0+1], 16'h2222);
        chk("rd_d2", wr_d[w0+2], 16'h3333);
        chk("rd_d3", wr_d[w0+3], 16'h4444);
        chk("rd_dones", done_n - d0, 1);

        a0 = act_d.size(); d0 = done_n; w0 = wr_a.size();
        go(1'b1, 13'd0, 13'h010);
        chk("len0_done", {31'b0, done}, 1);
        @(negedge clk);
        chk("len0_done_low", {31'b0, done}, 0);
        chk("len0_busy_low", {31'b0, busy}, 0);
        chk("len0_words", {19'b0, words_done}, 0);
        chk("len0_acts", act_d.size() - a0, 0);
        chk("len0_bufwe", wr_a.size() - w0, 0);
        chk("len0_dones", done_n - d0, 1);

        act_mark = act_n; a0 = act_d.size(); d0 = done_n; w0 = wr_a.size();
        go(1'b0, 13'd5, 13'h200);
        n = 0;
        while (!(act_n - act_mark == 2 && io.io_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ab_reach_word2", {31'b0, io.io_busy}, 1);
        abort = 1'b1;
        wait_done("ab");
        chk("ab_aborted", {31'b0, aborted}, 1);
        chk("ab_words", {19'b0, words_done}, 2);
        @(negedge clk);
        abort = 1'b0;
        chk("ab_acts", act_d.size() - a0, 2);
        chk("ab_writes", wr_a.size() - w0, 2);
        chk("ab_w2_addr", wr_a[w0+1], 13'h201);
        chk("ab_w2_data", wr_d[w0+1], 16'h2222);
        chk("ab_dones", done_n - d0, 1);
        go(1'b0, 13'd0, 13'h000);
        chk("ab_cleared", {31'b0, aborted}, 0);
        @(negedge clk);

        a0 = act_d.size();
        abort = 1'b1;
        go(1'b1, 13'd2, 13'h010);
        chk("abst_no_act", {31'b0, io.io_activate}, 0);
        wait_done("abst");
        chk("abst_aborted", {31'b0, aborted}, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abst_acts", act_d.size() - a0, 0);

        never_busy = 1'b1;
        d0 = done_n;
        go(1'b0, 13'd2, 13'h300);
        n = 0;
        while (!io.io_activate && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_act_seen", {31'b0, io.io_activate}, 1);
        repeat (8) @(negedge clk);
        chk("to_not_yet", {31'b0, timeout_err}, 0);
        @(negedge clk);
        chk("to_err", {31'b0, timeout_err}, 1);
        chk("to_done", {31'b0, done}, 1);
        chk("to_words", {19'b0, words_done}, 0);
        @(negedge clk);
        never_busy = 1'b0;
        chk("to_dones", done_n - d0, 1);

        go(1'b1, 13'd3, 13'h010);
        n = 0;
        while (!io.io_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_done", {31'b0, done}, 0);
        chk("rst_mid_io", {30'b0, io.io_activate, io.buf_we}, 0);
        @(negedge clk);
        nreset = 1'b1;
        a0 = act_d.size(); d0 = done_n;
        go(1'b1, 13'd1, 13'h100);
        wait_done("post");
        chk("post_words", {19'b0, words_done}, 1);
        chk("post_flags", {30'b0, aborted, timeout_err}, 0);
        @(negedge clk);
        chk("post_acts", act_d.size() - a0, 1);
        chk("post_data", act_d[a0], 16'hBEEF);
        chk("post_dones", done_n - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got running expected finished");
        $fatal(1);
    end
endmodule
